nibble_serializer: RTL

//  Transmit side of the bit-serial magnitude-compare path: accepts two parallel

---
 rtl/nibble_pkg.sv | 17 +
 rtl/nibble_serializer_if.sv | 31 +++
 rtl/piso_shift.sv | 28 ++
 rtl/nibble_serializer.sv | 104 ++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared types for the bit-serial magnitude-compare path.
// Used by the serializer and the comparator wrapper.
package nibble_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam int GAP_W = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Operand handshake in, serial bit pair plus frame flags out.
// master = operand source, slave = serializer.
interface nibble_serializer_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_a;
  logic             out_b;
  logic             out_valid;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready,
    input  out_a, out_b, out_valid,
    input  out_first, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready,
    output out_a, out_b, out_valid,
    output out_first, out_last
  );

endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out register, MSB first.
// Zero fill keeps the line at 0 once a frame is drained.
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/nibble_serializer.sv
// Serializes operand pairs MSB-first onto bm_a/bm_b with frame flags.
// FSM IDLE -> SHIFT -> (GAP) -> IDLE; back-to-back frames when GAP=0.
module nibble_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  nibble_serializer_if.slave  bus,
  output logic                busy
);

  import nibble_pkg::*;

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gcnt;
  logic             accept;
  logic             shift;

  assign bus.in_ready = !RESET &&
    ((state == IDLE) ||
     ((state == SHIFT) && (cnt == '0) && (GAP == 0)));

  assign accept = bus.in_valid && bus.in_ready;
  assign shift  = (state == SHIFT);

  piso_shift #(.WIDTH(WIDTH)) u_sa (
    .clk   (CLK),
    .rst   (RESET),
    .load  (accept),
    .shift (shift),
    .din   (bus.in_a),
    .msb   (bus.out_a)
  );

  piso_shift #(.WIDTH(WIDTH)) u_sb (
    .clk   (CLK),
    .rst   (RESET),
    .load  (accept),
    .shift (shift),
    .din   (bus.in_b),
    .msb   (bus.out_b)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      gcnt          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state         <= SHIFT;
            cnt           <= CNT_MAX;
            bus.out_valid <= 1'b1;
            bus.out_first <= 1'b1;
            bus.out_last  <= 1'b0;
            busy          <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt           <= cnt - 1'b1;
            bus.out_first <= 1'b0;
            bus.out_last  <= (cnt == CNT_W'(1));
          end else if (GAP > 0) begin
            state         <= nibble_pkg::GAP;
            gcnt          <= GAP_W'(GAP - 1);
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
          end else if (accept) begin
            cnt           <= CNT_MAX;
            bus.out_first <= 1'b1;
            bus.out_last  <= 1'b0;
          end else begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
          end
        end
        nibble_pkg::GAP: begin
          if (gcnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
